io_uart: RTL and testbench
==========================

Name: io_uart

Overview:
- Memory-mapped UART peripheral that acts as the responder on the non-cacheable IO bus driven by the GPGPU top level.
- Decodes io_address, accepts writes into a TX FIFO and serializes them onto uart_tx as 8N1 frames.
- Deserializes uart_rx into an RX FIFO, and returns status and RX data on io_read_data.
- Sits at the SoC/testbench level, outside the processor top.

Parameters:
- BASE_ADDRESS, 32'hFFFF0018, byte address of the first register; registers are at +0, +4 and +8.
- BAUD_DIVIDE, 16, clock cycles per serial bit. Must be an even number and at least 4.
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_write_en  input  1  single-cycle write strobe.
- io_read_en  input  1  single-cycle read strobe.
- io_address  input  32  byte address of the access.
- io_write_data  input  32  write data; only bits [7:0] are used.
- io_read_data  output  32  registered read data.
- uart_tx  output  1  serial output; idles high.
- uart_rx  input  1  serial input; asynchronous to clk.

Behaviour:
- Register map:
  - +0 STATUS (read-only). bit0 = TX FIFO not full. bit1 = RX FIFO not empty. bit2 = RX overrun (sticky). bit3 = frame error (sticky). Bits [31:4] read 0.
  - +4 RX_DATA (read). Returns {24'b0, head byte} and pops the RX FIFO. If the FIFO is empty it returns 0 and no state changes.
  - +8 TX_DATA (write). Pushes io_write_data[7:0]. If the TX FIFO is full the write is silently dropped.
- Writes to non-matching addresses, writes to +0/+4, and reads of +8 have no effect.
- Read latency is exactly 1 cycle: io_read_data is updated the cycle after io_read_en.
  - A read of a non-matching address gives io_read_data = 0, so that the system level can OR responders together.
  - When io_read_en is low, io_read_data holds its previous value.
- Reading STATUS clears bits 2 and 3 after they are returned. If a new overrun or frame error occurs in the same cycle, the set wins and the bit stays 1.
- TX path:
  - States: IDLE, START, DATA, STOP.
  - In IDLE with the TX FIFO not empty: pop the FIFO and load the shifter; uart_tx drives the start bit (0) from the next cycle.
  - Each bit is held for exactly BAUD_DIVIDE cycles. Data is sent LSB first, 8 bits, then the stop bit (1).
  - At the end of STOP, if the FIFO is not empty the next frame starts immediately (back-to-back frames, no idle gap); otherwise the state returns to IDLE.
  - A frame is exactly 10*BAUD_DIVIDE cycles.
- RX path:
  - uart_rx passes through a 2-flop synchronizer, adding 2 cycles of latency.
  - States: IDLE, START, DATA, STOP.
  - IDLE goes to START on a synchronized falling edge.
  - In START, the line is sampled BAUD_DIVIDE/2 cycles later (mid start bit). If it is high, it was a false start and the state returns to IDLE. If it is low, the state goes to DATA.
  - In DATA, 8 bits are sampled every BAUD_DIVIDE cycles, LSB first.
  - In STOP, the stop bit is sampled after a further BAUD_DIVIDE cycles:
    - If the stop bit is 0: set the frame-error bit, discard the byte, and go to IDLE.
    - If the stop bit is 1: push the byte. If the RX FIFO is full, set the overrun bit and discard the byte.
- FIFOs:
  - Push and pop in the same cycle are both honoured. When the FIFO is full, the pop takes effect first, so the push succeeds and no overrun is flagged.
  - Pointers wrap modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.
- Reset values:
  - uart_tx = 1 and io_read_data = 0.
  - Both FIFOs are empty and both state machines are in IDLE.
  - Sticky bits are 0.
  - Reset asserted mid-frame aborts the frame; uart_tx is 1 on the cycle after reset is sampled.

Test Plan:
- Write 0x41 to +8 (BAUD_DIVIDE=16). uart_tx must be low for 16 cycles, then drive bits 1,0,0,0,0,0,1,0 at 16 cycles each, then high for 16 cycles. The total frame is 160 cycles.
- Write 9 bytes back-to-back while the TX FIFO is initially empty. The first byte is popped immediately, so all 9 are accepted. Further writes while STATUS bit0 = 0 are dropped. All accepted frames go out with no idle gap between them.
- Drive the 8N1 frame for 0x5A on uart_rx. STATUS must read 0x3 (bit1 = 1). Reading +4 must return 0x0000005A one cycle later, after which STATUS reads 0x1.
- Receive 9 frames without reading. The 9th byte is discarded and STATUS reads 0x7. A second STATUS read returns 0x3, and RX_DATA reads return the first 8 bytes in order.
- Drive a frame with the stop bit at 0 → STATUS bit3 = 1 and the RX FIFO stays empty. Drive a 4-cycle low glitch → nothing is received and no flags are set.
- Assert reset during the 5th data bit of a TX frame → uart_tx = 1 on the next cycle, STATUS reads 0x1, and reads of an unmapped address return 0.

Source files
------------

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART responder for the non-cacheable IO bus.
// STATUS at +0, RX_DATA at +4 (read pops), TX_DATA at +8 (write pushes).

// Byte FIFO with an extra count bit so that full and empty are distinct.
module io_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
            else if (!push_i && pop_i) cnt_q <= cnt_q - CW'(1);
        end
    end
endmodule

module io_uart #(
    parameter logic [31:0] BASE_ADDRESS = 32'hFFFF0018,
    parameter int          BAUD_DIVIDE  = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int BW = $clog2(BAUD_DIVIDE);
    localparam logic [BW-1:0] FULL_BIT = BW'(BAUD_DIVIDE - 1);
    localparam logic [BW-1:0] HALF_BIT = BW'(BAUD_DIVIDE / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic sel_status, sel_rx, sel_tx;
    assign sel_status = (io_address == BASE_ADDRESS);
    assign sel_rx     = (io_address == BASE_ADDRESS + 32'd4);
    assign sel_tx     = (io_address == BASE_ADDRESS + 32'd8);

    logic unused_wdata;
    assign unused_wdata = ^io_write_data[31:8];

    // ---------------- FIFOs ----------------
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_frame_ok;
    logic [7:0] tx_rdata, rx_rdata;

    // A full FIFO still accepts a push when it is being popped in the same cycle.
    assign tx_push = io_write_en && sel_tx && (!tx_full || tx_pop);
    assign rx_pop  = io_read_en && sel_rx && !rx_empty;
    assign rx_push = rx_frame_ok && (!rx_full || rx_pop);

    io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(io_write_data[7:0]), .rdata_o(tx_rdata),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    // ---------------- TX path ----------------
    state_e        tx_state_q, tx_state_d;
    logic [BW-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    // TX state register; uart_tx is registered so reset forces the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // TX next state: each bit held for one baud period; STOP chains into the next frame.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        if (tx_state_q != S_IDLE && tx_baud_q != '0) begin
            tx_baud_d = tx_baud_q - BW'(1);
        end else begin
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_baud_d  = FULL_BIT;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end
                S_DATA: begin
                    tx_baud_d = FULL_BIT;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
                default: begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_state_d = S_START;
                        tx_baud_d  = FULL_BIT;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    assign uart_tx = tx_q;

    // ---------------- RX path ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    state_e        rx_state_q, rx_state_d;
    logic [BW-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          ferr_set, ovr_set;

    io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_shift_q), .rdata_o(rx_rdata),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: half a bit to mid start, then one full bit per sample.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_frame_ok = 1'b0;
        ferr_set    = 1'b0;
        if (rx_state_q == S_IDLE) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_baud_d  = HALF_BIT;
            end
        end else if (rx_baud_q != '0) begin
            rx_baud_d = rx_baud_q - BW'(1);
        end else begin
            rx_baud_d = FULL_BIT;
            case (rx_state_q)
                S_START: begin
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    rx_bit_d   = 3'd0;
                end
                S_DATA: begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
                default: begin
                    rx_state_d  = S_IDLE;
                    rx_frame_ok = rx_s2_q;
                    ferr_set    = !rx_s2_q;
                end
            endcase
        end
    end

    assign ovr_set = rx_frame_ok && rx_full && !rx_pop;

    // ---------------- Status and read port ----------------
    logic        ovr_q, ferr_q;
    logic [31:0] rdata_q;

    // Sticky error bits; a STATUS read clears them unless a new event lands that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else if (io_read_en && sel_status) begin
            ovr_q  <= ovr_set;
            ferr_q <= ferr_set;
        end else begin
            ovr_q  <= ovr_q | ovr_set;
            ferr_q <= ferr_q | ferr_set;
        end
    end

    // Registered read data; unmapped reads return 0 so responders can be OR-ed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (io_read_en) begin
            if (sel_status)
                rdata_q <= {28'b0, ferr_q, ovr_q, !rx_empty, !tx_full};
            else if (sel_rx && !rx_empty)
                rdata_q <= {24'b0, rx_rdata};
            else
                rdata_q <= '0;
        end
    end

    assign io_read_data = rdata_q;
endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: frame-level model checked every cycle plus literal checks.
module tb_io_uart;
    localparam logic [31:0] A_ST   = 32'hFFFF0018;
    localparam logic [31:0] A_RX   = 32'hFFFF001C;
    localparam logic [31:0] A_TX   = 32'hFFFF0020;
    localparam logic [31:0] A_NONE = 32'h10000000;

    logic        clk = 1'b0;
    logic        reset, io_write_en, io_read_en, uart_tx, uart_rx;
    logic [31:0] io_address, io_write_data, io_read_data;

    io_uart dut (
        .clk(clk), .reset(reset), .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: byte queues and the frame currently on the wire.
    logic [7:0]  mq_tx[$];
    logic [7:0]  mq_rx[$];
    bit          m_active, m_ovr, m_ferr;
    bit          m_valid = 0;
    int          m_pos;
    logic [7:0]  m_byte;
    logic        exp_tx;
    logic [31:0] exp_rd;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Model step at every rising edge, using the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        if (reset) begin
            mq_tx.delete(); mq_rx.delete();
            m_active = 0; m_ovr = 0; m_ferr = 0; m_pos = 0;
            exp_tx = 1'b1; exp_rd = 32'h0; m_valid = 1;
        end else begin
            if (io_read_en) begin
                if (io_address == A_ST) begin
                    exp_rd = {28'b0, m_ferr, m_ovr, mq_rx.size() != 0, mq_tx.size() < 8};
                    m_ovr = 0; m_ferr = 0;
                end else if (io_address == A_RX && mq_rx.size() != 0)
                    exp_rd = {24'b0, mq_rx.pop_front()};
                else
                    exp_rd = 32'h0;
            end
            if (m_active) begin
                if (m_pos == 159) m_active = 0;
                else m_pos++;
            end
            if (!m_active && mq_tx.size() != 0) begin
                m_byte = mq_tx.pop_front(); m_active = 1; m_pos = 0;
            end
            if (io_write_en && io_address == A_TX && mq_tx.size() < 8)
                mq_tx.push_back(io_write_data[7:0]);
            exp_tx = m_active ? frame_bit(m_byte, m_pos / 16) : 1'b1;
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx});
            check("io_read_data", io_read_data, exp_rd);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        io_write_en = 1'b1; io_address = a; io_write_data = {24'hA5A5A5, d};
        @(posedge clk); #1;
        io_write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        io_read_en = 1'b1; io_address = a;
        @(posedge clk); #1;
        io_read_en = 1'b0;
        v = io_read_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            uart_rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            repeat (16) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        idle(20);
        if (!stop) m_ferr = 1;
        else if (mq_rx.size() < 8) mq_rx.push_back(b);
        else m_ovr = 1;
    endtask

    logic [31:0] v;
    logic [9:0]  exp41;

    initial begin
        reset = 1'b1; io_write_en = 1'b0; io_read_en = 1'b0;
        io_address = 32'h0; io_write_data = 32'h0; uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_rd", io_read_data, 32'h0);
        rd(A_ST, v); check("status_after_reset", v, 32'h1);

        // Single frame 0x41, sampled mid-bit; wire order is start, LSB..MSB, stop.
        exp41 = 10'b1010000010;
        wr(A_TX, 8'h41);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            repeat (8) @(posedge clk);
            #1 check($sformatf("tx41_bit%0d", k), {31'b0, uart_tx}, {31'b0, exp41[k]});
            repeat (8) @(posedge clk);
        end
        #1 idle(4);

        // Nine back-to-back writes fill the FIFO; a tenth is dropped.
        for (int i = 0; i < 9; i++) wr(A_TX, 8'h10 + 8'(i));
        rd(A_ST, v); check("status_tx_full", v, 32'h0);
        wr(A_TX, 8'hEE);
        idle(9 * 160 + 20);
        rd(A_ST, v); check("status_tx_drained", v, 32'h1);

        // Single RX frame.
        send_rx(8'h5A, 1'b1);
        rd(A_ST, v); check("status_rx_ready", v, 32'h3);
        rd(A_TX, v); check("read_tx_reg_zero", v, 32'h0);
        rd(A_RX, v); check("rx_5a", v, 32'h5A);
        rd(A_ST, v); check("status_rx_empty", v, 32'h1);

        // Overrun: nine frames, ninth discarded.
        for (int i = 0; i < 9; i++) send_rx(8'hC0 + 8'(i), 1'b1);
        rd(A_ST, v); check("status_overrun", v, 32'h7);
        rd(A_ST, v); check("status_overrun_cleared", v, 32'h3);
        for (int i = 0; i < 8; i++) begin
            rd(A_RX, v); check($sformatf("rx_fifo_%0d", i), v, 32'hC0 + i);
        end
        rd(A_RX, v); check("rx_empty_read", v, 32'h0);
        rd(A_ST, v); check("status_after_drain", v, 32'h1);

        // Frame error, then a short glitch.
        send_rx(8'hA5, 1'b0);
        rd(A_ST, v); check("status_frame_err", v, 32'h9);
        rd(A_ST, v); check("status_ferr_cleared", v, 32'h1);
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(40);
        rd(A_ST, v); check("status_after_glitch", v, 32'h1);
        rd(A_RX, v); check("rx_after_glitch", v, 32'h0);

        // Reset during the fifth data bit of a frame.
        wr(A_TX, 8'h3C);
        idle(1 + 85);
        check("tx_mid_frame_bit4", {31'b0, uart_tx}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("tx_after_reset", {31'b0, uart_tx}, 32'h1);
        rd(A_ST, v); check("status_after_midreset", v, 32'h1);
        rd(A_NONE, v); check("unmapped_read", v, 32'h0);
        idle(200);
        check("tx_idle_after_reset", {31'b0, uart_tx}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
